spi_reg_responder: RTL and testbench

- SPI mode-0 slave (responder) exposing a 32 x 8 register file.
- Uses a MAX3421E-style command byte, so it mirrors the on-board USB controller's register protocol from the device side.
- Used as the peripheral end of the soc SPI master: as a bench model for USB driver bring-up and as an Arduino-header target for debug.
- SCLK, CS_N and MOSI are oversampled in the system clock domain; there is no second clock.

---
 rtl/spi_reg_pkg.sv | 16 +
 rtl/spi_reg_responder_if.sv | 26 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_reg_responder.sv | 141 ++++++++++++++
 tb/tb_spi_reg_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and command-byte layout for the SPI register responder.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_DIR_BIT  = 1;

  localparam logic [7:0] WRITE_DUMMY = 8'h00;

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle between a bus master and the register responder.
interface spi_reg_responder_if;

  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detect on the synced level.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {STAGES{IDLE_VAL}};
      prev <= IDLE_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder over a register file, MAX3421E-style command byte,
// with all SPI pins oversampled in the system clock domain.
module spi_reg_responder
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_reg_responder_if.slave spi,
  input  logic [7:0]        status,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_strobe,
  output logic              busy
);

  localparam int NREG = 1 << ADDR_W;
  localparam bit INC  = (AUTO_INC != 0);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
    .clk(clk), .reset_n(reset_n), .din(spi.spi_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs (
    .clk(clk), .reset_n(reset_n), .din(spi.spi_cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .din(spi.spi_mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused = ^{sclk_q, mosi_rise, mosi_fall};

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [7:0]        next_byte;
  logic [ADDR_W-1:0] addr;
  logic              dir_wr;
  logic [7:0]        regs [NREG];

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] rd_addr;

  assign rx_byte   = {rx_shift, mosi_q};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign cmd_addr  = ADDR_W'(rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
  assign addr_inc  = addr + ADDR_W'(1);
  assign rd_addr   = INC ? addr_inc : addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      next_byte <= '0;
      addr      <= '0;
      dir_wr    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_strobe <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wr_valid  <= 1'b0;
      rd_strobe <= 1'b0;
      // SPI write below is scheduled later, so it wins a same-cycle clash
      if (host_we) regs[host_addr] <= host_wdata;
      if (cs_fall) begin
        state    <= CMD;
        bit_cnt  <= '0;
        tx_shift <= status;
      end else if (cs_rise) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          unique case (1'b1)
            state == CMD: begin
              addr   <= cmd_addr;
              dir_wr <= rx_byte[CMD_DIR_BIT];
              state  <= DATA;
              if (rx_byte[CMD_DIR_BIT]) begin
                next_byte <= WRITE_DUMMY;
              end else begin
                next_byte <= regs[cmd_addr];
                rd_strobe <= 1'b1;
              end
            end
            state == DATA: begin
              if (dir_wr) begin
                regs[addr] <= rx_byte;
                wr_valid   <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= rx_byte;
                if (INC) addr <= addr_inc;
              end else begin
                addr      <= rd_addr;
                next_byte <= regs[rd_addr];
                rd_strobe <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) tx_shift <= next_byte;
          else tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi.spi_miso_oe = ~cs_q;
  assign spi.spi_miso    = ~cs_q & tx_shift[7];
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized frame bench for spi_reg_responder against a register-level model.
module tb_spi_reg_responder;

  localparam int AUTO_INC = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] status = 8'h00;
  logic       host_we = 1'b0;
  logic [4:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_strobe;
  logic       busy;

  spi_reg_responder_if spi ();

  spi_reg_responder #(
    .SYNC_STAGES(2), .AUTO_INC(AUTO_INC), .ADDR_W(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spi(spi),
    .status(status), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_strobe(rd_strobe), .busy(busy)
  );

  always #10 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mregs [32];
  logic [7:0]  exp_miso [$];
  logic [12:0] exp_wr [$];
  int          rd_cnt = 0;
  int          rd_exp = 0;
  int          wr_cnt = 0;
  logic [12:0] last_wr = '0;
  logic [12:0] wr_e;
  logic [7:0]  frm [40];
  logic [7:0]  got [40];
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // per-cycle compare of the write/read side-band outputs
  always @(negedge clk) begin
    if (chk_en) begin
      if (!spi.spi_miso_oe) check("miso_idle", 32'(spi.spi_miso), 32'd0);
      if (wr_valid) begin
        wr_cnt++;
        last_wr = {wr_addr, wr_data};
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: got %0h want none", {wr_addr, wr_data});
        end else begin
          wr_e = exp_wr.pop_front();
          check("wr_pulse", 32'({wr_addr, wr_data}), 32'(wr_e));
        end
      end
      if (rd_strobe) rd_cnt++;
    end
  end

  task automatic model_frame(input int nfull, input logic [7:0] st);
    logic [4:0] a;
    logic       wr;
    a  = frm[0][7:3];
    wr = frm[0][1];
    exp_miso.push_back(st);
    if (!wr) rd_exp++;
    for (int i = 1; i <= nfull; i++) begin
      if (wr) begin
        exp_miso.push_back(8'h00);
        exp_wr.push_back({a, frm[i]});
        mregs[a] = frm[i];
      end else begin
        exp_miso.push_back(mregs[a]);
        rd_exp++;
      end
      if (AUTO_INC != 0) a = a + 5'd1;
    end
  endtask

  task automatic spi_frame(input int nbytes, input int trunc,
                           input bit collide, input bit keep_cs);
    int nb;
    logic [7:0] cap;
    logic [7:0] e;
    spi.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int j = 0; j < nbytes + ((trunc > 0) ? 1 : 0); j++) begin
      nb  = (j < nbytes) ? 8 : trunc;
      cap = '0;
      for (int b = 0; b < nb; b++) begin
        spi.spi_mosi = frm[j][7-b];
        repeat (4) @(negedge clk);
        cap = {cap[6:0], spi.spi_miso};
        spi.spi_sclk = 1'b1;
        if (collide && j == nbytes - 1 && b == 7) begin
          repeat (2) @(negedge clk);
          host_we = 1'b1;
          host_addr = 5'd7;
          host_wdata = 8'h55;
          @(negedge clk);
          host_we = 1'b0;
          @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
        spi.spi_sclk = 1'b0;
      end
      if (j < nbytes) begin
        got[j] = cap;
        if (exp_miso.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL miso_extra: got %0h want none", cap);
        end else begin
          e = exp_miso.pop_front();
          check($sformatf("miso_byte%0d", j), 32'(cap), 32'(e));
        end
      end
    end
    repeat (8) @(negedge clk);
    if (!keep_cs) begin
      spi.spi_cs_n = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic run(input int nfull, input int trunc, input bit collide);
    model_frame(nfull, status);
    spi_frame(nfull + 1, trunc, collide, 1'b0);
    check("wr_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_strobes", 32'(rd_cnt), 32'(rd_exp));
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    mregs[a] = d;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int tr;
    spi.spi_sclk = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.spi_mosi = 1'b0;
    foreach (mregs[i]) mregs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(spi.spi_miso_oe), 32'd0);
    check("rst_miso", 32'(spi.spi_miso), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_strobe", 32'(rd_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1'b1;

    status = 8'h3C;
    frm[0] = 8'h2A; frm[1] = 8'hA5;
    run(1, 0, 1'b0);
    check("wr_status_byte", 32'(got[0]), 32'h3C);
    check("wr_dummy_byte", 32'(got[1]), 32'h00);
    check("wr_literal", 32'(last_wr), 32'({5'd5, 8'hA5}));
    check("wr_count", 32'(wr_cnt), 32'd1);

    frm[0] = 8'h28; frm[1] = 8'h00;
    run(1, 0, 1'b0);
    check("readback_lit", 32'(got[1]), 32'hA5);

    frm[0] = 8'hFA; frm[1] = 8'h11; frm[2] = 8'h22;
    run(2, 0, 1'b0);
    frm[0] = 8'hF8; frm[1] = 8'h00; frm[2] = 8'h00;
    run(2, 0, 1'b0);
    check("wrap_reg31", 32'(got[1]), 32'h11);
    check("wrap_reg0", 32'(got[2]), 32'h22);

    frm[0] = 8'h2A; frm[1] = 8'h3E;
    run(0, 5, 1'b0);
    frm[0] = 8'h28; frm[1] = 8'h00;
    run(1, 0, 1'b0);
    check("abort_kept", 32'(got[1]), 32'hA5);

    frm[0] = 8'h3A; frm[1] = 8'h99;
    run(1, 0, 1'b1);
    frm[0] = 8'h38; frm[1] = 8'h00;
    run(1, 0, 1'b0);
    check("collide_spi_wins", 32'(got[1]), 32'h99);

    host_write(5'd9, 8'h6B);
    frm[0] = 8'h48; frm[1] = 8'h00;
    run(1, 0, 1'b0);
    check("host_write_lit", 32'(got[1]), 32'h6B);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0)
        host_write(5'($urandom), 8'($urandom));
      status = 8'($urandom);
      n = $urandom_range(0, 4);
      for (int i = 0; i <= n + 1; i++) frm[i] = 8'($urandom);
      tr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run(n, tr, 1'b0);
    end

    status = 8'hC3;
    frm[0] = 8'h12; frm[1] = 8'h77;
    model_frame(0, status);
    spi_frame(1, 4, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_oe", 32'(spi.spi_miso_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    foreach (mregs[i]) mregs[i] = 8'h00;
    repeat (2) @(negedge clk);
    spi.spi_cs_n = 1'b1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    frm[0] = 8'h00;
    for (int i = 1; i <= 32; i++) frm[i] = 8'h00;
    run(32, 0, 1'b0);
    check("midrst_reg5_clr", 32'(got[6]), 32'h00);
    frm[0] = 8'h82; frm[1] = 8'h5A;
    run(1, 0, 1'b0);
    frm[0] = 8'h80; frm[1] = 8'h00;
    run(1, 0, 1'b0);
    check("post_rst_frame", 32'(got[1]), 32'h5A);
    check("miso_q_drained", 32'(exp_miso.size()), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
